// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: manual modes, FSM states,
// burst directions, per-bit select codes and the debug view of the controller.
package usr_pkg;

  localparam logic [2:0] HOLD = 3'b000;
  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] SHR  = 3'b010;
  localparam logic [2:0] SHL  = 3'b011;
  localparam logic [2:0] ROR  = 3'b100;
  localparam logic [2:0] ROL  = 3'b101;
  localparam logic [2:0] CLR  = 3'b110;

  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;

  typedef enum logic {IDLE, SHIFT} state_e;

  // HI takes the higher-index neighbour (shift right), LO the lower (shift left).
  typedef enum logic [2:0] {SEL_HOLD, SEL_LOAD, SEL_HI, SEL_LO, SEL_ZERO} sel_e;

  typedef struct packed {
    state_e     state;
    logic       dir;
    logic [5:0] cnt;
  } usr_dbg_t;

endpackage

// File: rtl/usr_bit_cell.sv
// One register bit's next-value mux: hold, load, take a neighbour, or clear.
module usr_bit_cell
  import usr_pkg::*;
(
  input  sel_e sel,
  input  logic d,
  input  logic q,
  input  logic hi_nb,
  input  logic lo_nb,
  output logic nxt
);

  always_comb begin
    nxt = q;
    case (sel)
      SEL_LOAD: nxt = d;
      SEL_HI:   nxt = hi_nb;
      SEL_LO:   nxt = lo_nb;
      SEL_ZERO: nxt = 1'b0;
      default:  nxt = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-generic universal shift register with manual modes and a START-driven
// burst serialiser that shifts a loaded word out on SO over WIDTH cycles.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  input  logic [2:0]       MODE,
  input  logic             START,
  input  logic             DIR,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             BUSY,
  output logic             DONE,
  output usr_dbg_t         DBG
);

  localparam int CW = $clog2(WIDTH);

  // Handshake: START is a request taken on any edge where BUSY is low (including
  // the DONE cycle); while BUSY is high START, MODE and DIR are ignored; DONE
  // pulses for the single cycle after the last shift.

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             done_d;
  logic [WIDTH-1:0] q_d;
  sel_e             sel;
  logic             fill_hi, fill_lo;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    sel     = SEL_HOLD;
    fill_hi = SI;
    fill_lo = SI;
    case (state_q)
      IDLE: begin
        if (START) begin
          sel     = SEL_LOAD;
          state_d = SHIFT;
          cnt_d   = '0;
          dir_d   = DIR;
        end else begin
          case (MODE)
            LOAD: sel = SEL_LOAD;
            SHR: begin
              sel   = SEL_HI;
              dir_d = DIR_LSB;
            end
            SHL: begin
              sel   = SEL_LO;
              dir_d = DIR_MSB;
            end
            ROR: begin
              sel     = SEL_HI;
              fill_hi = Q[0];
              dir_d   = DIR_LSB;
            end
            ROL: begin
              sel     = SEL_LO;
              fill_lo = Q[WIDTH-1];
              dir_d   = DIR_MSB;
            end
            CLR:     sel = SEL_ZERO;
            default: sel = SEL_HOLD;
          endcase
        end
      end
      SHIFT: begin
        sel = (dir_q == DIR_MSB) ? SEL_LO : SEL_HI;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic hi_nb, lo_nb;
    if (i == WIDTH - 1) begin : g_hi_edge
      assign hi_nb = fill_hi;
    end else begin : g_hi_mid
      assign hi_nb = Q[i+1];
    end
    if (i == 0) begin : g_lo_edge
      assign lo_nb = fill_lo;
    end else begin : g_lo_mid
      assign lo_nb = Q[i-1];
    end
    usr_bit_cell u_cell (
      .sel   (sel),
      .d     (D[i]),
      .q     (Q[i]),
      .hi_nb (hi_nb),
      .lo_nb (lo_nb),
      .nxt   (q_d[i])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_LSB;
      Q       <= '0;
      DONE    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      Q       <= q_d;
      DONE    <= done_d;
    end
  end

  assign BUSY = (state_q == SHIFT);
  assign SO   = (dir_q == DIR_MSB) ? Q[WIDTH-1] : Q[0];
  assign DBG  = '{state: state_q, dir: dir_q, cnt: 6'(cnt_q)};

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg at WIDTH=8: manual modes, reset abort,
// and burst serialisation with a scoreboard of expected SO bits.
module tb_univ_shift_reg;
  import usr_pkg::*;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] D = '0;
  logic         SI = 1'b0;
  logic [2:0]   MODE = HOLD;
  logic         START = 1'b0;
  logic         DIR = 1'b0;
  logic [W-1:0] Q;
  logic         SO, BUSY, DONE;
  usr_dbg_t     DBG;

  int n_checks = 0;
  int n_pass   = 0;
  logic exp_q[$];

  univ_shift_reg #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .D(D), .SI(SI), .MODE(MODE), .START(START),
    .DIR(DIR), .Q(Q), .SO(SO), .BUSY(BUSY), .DONE(DONE), .DBG(DBG)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic manual(input logic [2:0] m, input logic [W-1:0] d, input logic si);
    MODE = m; D = d; SI = si;
    step();
  endtask

  // Runs one burst; the DUT is expected to accept START on the first edge.
  task automatic burst(input logic [W-1:0] d, input logic dir, input logic si,
                       input bit mess, input bit hold_start, input logic [W-1:0] q_final);
    for (int k = 0; k < W; k++) exp_q.push_back(dir ? d[W-1-k] : d[k]);
    D = d; DIR = dir; SI = si; MODE = HOLD; START = 1'b1;
    step();
    if (!hold_start) START = 1'b0;
    for (int k = 0; k < W; k++) begin
      check("burst_busy", BUSY, 1);
      if (k > 0) check("burst_done_low", DONE, 0);
      if (exp_q.size() == 0) check("scoreboard_empty", 1, 0);
      else check("burst_so", SO, exp_q.pop_front());
      if (mess) begin
        MODE  = k[0] ? CLR : LOAD;
        DIR   = ~dir;
        D     = ~d;
        START = (k < W - 1) ? k[0] : 1'b0;
      end
      step();
    end
    MODE = HOLD;
    check("end_busy", BUSY, 0);
    check("end_done", DONE, 1);
    check("end_q", Q, q_final);
  endtask

  logic [W-1:0] model;

  initial begin
    // reset held from time 0
    step(); step();
    check("rst_q", Q, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_state", DBG.state, IDLE);
    RST = 1'b0;

    // reset mid-burst aborts immediately
    manual(LOAD, 8'hA5, 0);
    check("load_a5", Q, 8'hA5);
    MODE = HOLD; D = 8'hA5; START = 1'b1;
    step();
    START = 1'b0;
    check("pre_rst_busy", BUSY, 1);
    check("pre_rst_q", Q, 8'hA5);
    #2 RST = 1'b1;
    #1;
    check("async_rst_q", Q, 0);
    check("async_rst_busy", BUSY, 0);
    check("async_rst_done", DONE, 0);
    RST = 1'b0;
    step();
    check("post_rst_busy", BUSY, 0);
    check("post_rst_done", DONE, 0);
    check("post_rst_q", Q, 0);

    // manual load / shift right / rotate left
    manual(LOAD, 8'h96, 0);
    check("load_96", Q, 8'h96);
    manual(SHR, 8'h00, 1);
    check("shr1", Q, 8'hCB);
    manual(SHR, 8'h00, 1);
    check("shr2", Q, 8'hE5);
    check("so_right", SO, 1);
    manual(ROL, 8'h00, 0);
    check("rol", Q, 8'hCB);
    check("so_left", SO, 1);
    manual(SHL, 8'h00, 0);
    check("shl", Q, 8'h96);
    check("so_left_msb", SO, 1);

    // rotate right eight times returns to the start value
    manual(LOAD, 8'h81, 0);
    model = 8'h81;
    for (int i = 0; i < W; i++) begin
      manual(ROR, 8'h00, 0);
      model = {model[0], model[W-1:1]};
      if (i == 0) check("ror1", Q, model);
    end
    check("ror8", Q, 8'h81);
    check("so_after_ror", SO, 1);
    manual(CLR, 8'hFF, 1);
    check("clr", Q, 0);
    manual(LOAD, 8'h3C, 0);
    manual(3'b111, 8'hFF, 1);
    check("reserved_hold", Q, 8'h3C);
    manual(HOLD, 8'hFF, 1);
    check("hold", Q, 8'h3C);

    // bursts
    burst(8'hB2, DIR_LSB, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check("done_one_cycle", DONE, 0);
    check("idle_after_burst", BUSY, 0);
    burst(8'hB2, DIR_MSB, 1'b1, 1'b1, 1'b0, 8'hFF);
    step();
    check("done_one_cycle2", DONE, 0);

    // START held: second burst accepted in the DONE cycle
    burst(8'h0F, DIR_LSB, 1'b0, 1'b0, 1'b1, 8'h00);
    burst(8'hF0, DIR_LSB, 1'b0, 1'b0, 1'b0, 8'h00);
    step();
    check("b2b_idle", BUSY, 0);
    check("b2b_done_low", DONE, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
